seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 122 ++++++++++++
 tb/tb_seq_divider.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: 16/8 unsigned restoring divider, one quotient bit per clock.
// Optional build macro SEQ_DIVIDER_ZERO_FAST_EN: a zero divisor completes one
// cycle after acceptance instead of running all 16 iterations.
module seq_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] q_q, q_d;
    logic [7:0]  d_q, d_d;
    logic [7:0]  r_q, r_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dbz_q, dbz_d;
    logic [15:0] quotient_q, quotient_d;
    logic [7:0]  remainder_q, remainder_d;
    logic        div_by_zero_q, div_by_zero_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [8:0]  t;
    logic        ge;
    logic [7:0]  diff;

    // Trial subtraction: R < D always holds, so T - D fits in 8 bits when T >= D.
    assign t    = {r_q, q_q[15]};
    assign ge   = t >= {1'b0, d_q};
    assign diff = t[7:0] - d_q;

    // Next-state logic: accept, iterate, and publish results on the 16th step.
    always_comb begin
        state_d       = state_q;
        q_d           = q_q;
        d_d           = d_q;
        r_d           = r_q;
        cnt_d         = cnt_q;
        dbz_d         = dbz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        done_d        = 1'b0;
        case (state_q)
            RUN: begin
                q_d   = {q_q[14:0], ge};
                r_d   = ge ? diff : t[7:0];
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d       = DONE;
                    quotient_d    = q_d;
                    remainder_d   = r_d;
                    div_by_zero_d = dbz_q;
                    done_d        = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    state_d = RUN;
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = 8'd0;
                    cnt_d   = 4'd0;
                    dbz_d   = (divisor == 8'd0);
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
                    if (divisor == 8'd0) begin
                        state_d       = DONE;
                        quotient_d    = 16'hFFFF;
                        remainder_d   = dividend[7:0];
                        div_by_zero_d = 1'b1;
                        done_d        = 1'b1;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
        busy_d = (state_d == RUN);
    end

    // State and registered outputs; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            q_q           <= '0;
            d_q           <= '0;
            r_q           <= '0;
            cnt_q         <= '0;
            dbz_q         <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            q_q           <= q_d;
            d_q           <= d_d;
            r_q           <= r_d;
            cnt_q         <= cnt_d;
            dbz_q         <= dbz_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against an arithmetic model.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        busy;
    logic        done;
    int          total = 0;
    int          bad = 0;

`ifdef SEQ_DIVIDER_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    seq_divider dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor gives all-ones quotient, low dividend byte.
    function automatic logic [24:0] model(input logic [15:0] a, input logic [7:0] b);
        logic [15:0] mq;
        logic [7:0]  mr;
        if (b == 8'd0) return {1'b1, 16'hFFFF, a[7:0]};
        mq = a / {8'd0, b};
        mr = 8'(a % {8'd0, b});
        return {1'b0, mq, mr};
    endfunction

    function automatic int lat_for(input logic [7:0] b);
        return (FAST && b == 8'd0) ? 0 : 16;
    endfunction

    // Present an operation and step past the accept edge E0.
    task automatic go(input logic [15:0] a, input logic [7:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("acc_done", done, lat_for(b) == 0);
        chk("acc_busy", busy, lat_for(b) != 0);
    endtask

    // Wait (bounded) for done; k0 = iteration edges already consumed since E0.
    task automatic fin(input logic [15:0] eq, input logic [7:0] er, input logic ez,
                       input int elat, input int k0, input string tag);
        int k = k0;
        int bc = 0;
        while (!done && k < 40) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, ":lat"}, k, elat);
        chk({tag, ":busy_cycles"}, bc, elat - k0);
        chk({tag, ":done"}, done, 1);
        chk({tag, ":busy_at_done"}, busy, 0);
        chk({tag, ":quot"}, quotient, eq);
        chk({tag, ":rem"}, remainder, er);
        chk({tag, ":dbz"}, div_by_zero, ez);
    endtask

    task automatic op(input logic [15:0] a, input logic [7:0] b, input string tag);
        logic [24:0] m;
        m = model(a, b);
        go(a, b);
        fin(m[23:8], m[7:0], m[24], lat_for(b), 0, tag);
    endtask

    initial begin
        logic [7:0]  x, y;
        logic [15:0] a;
        int          dc;
        #3;
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);

        go(16'h03E8, 8'h07);
        fin(16'h008E, 8'h06, 1'b0, 16, 0, "basic");
        go(16'hFFFF, 8'h01);
        fin(16'hFFFF, 8'h00, 1'b0, 16, 0, "ffff_1");
        go(16'h00FF, 8'hFF);
        fin(16'h0001, 8'h00, 1'b0, 16, 0, "00ff_ff");
        go(16'h0005, 8'hFF);
        fin(16'h0000, 8'h05, 1'b0, 16, 0, "0005_ff");
        go(16'hFFFF, 8'hFF);
        fin(16'h0101, 8'h00, 1'b0, 16, 0, "ffff_ff");
        go(16'h1234, 8'h00);
        fin(16'hFFFF, 8'h34, 1'b1, FAST ? 0 : 16, 0, "divzero");

        go(16'h1234, 8'h56);
        repeat (4) @(posedge clk);
        #1;
        dividend = 16'h0064;
        divisor  = 8'h03;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        fin(16'h0036, 8'h10, 1'b0, 16, 5, "ignored_start");
        go(16'h0064, 8'h03);
        fin(16'h0021, 8'h01, 1'b0, 16, 0, "back_to_back");

        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom_range(1, 255));
            y = 8'($urandom_range(0, 255));
            go(16'(x) * 16'(y), x);
            fin(16'(y), 8'h00, 1'b0, 16, 0, "roundtrip");
        end
        for (int i = 1; i < 256; i++) begin
            x = 8'(i);
            go(16'(x) * 16'hFF, x);
            fin(16'h00FF, 8'h00, 1'b0, 16, 0, "sweep");
        end
        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom);
            x = (i % 10 == 0) ? 8'h00 : 8'($urandom);
            op(a, x, "random");
        end

        go(16'hFFFF, 8'h01);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_quot", quotient, 0);
        chk("mid_rst_rem", remainder, 0);
        chk("mid_rst_dbz", div_by_zero, 0);
        #10 rst_n = 1'b1;
        dc = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done || busy) dc++;
        end
        chk("no_done_after_rst", dc, 0);
        op(16'h1234, 8'h12, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
